// File: rtl/simon_sequencer.sv
// Simon game controller: grows a random colour sequence, plays it back, then checks the player's replay.
// Outputs are registered and update one cycle after the causing edge. start and press are single-cycle pulses with no backpressure.
module simon_sequencer #(
    parameter int MAX_LEN       = 32,
    parameter int ON_TICKS      = 25_000_000,
    parameter int OFF_TICKS     = 12_500_000,
    parameter int TIMEOUT_TICKS = 250_000_000,
    localparam int LW = $clog2(MAX_LEN + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          press,
    input  logic [1:0]    press_color,
    input  logic [1:0]    rnd,
    output logic [1:0]    color,
    output logic          led_enable,
    output logic [2:0]    state,
    output logic [LW-1:0] score,
    output logic          game_over,
    output logic          win
);
    localparam int MAX_ON_OFF = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int MAX_T      = (MAX_ON_OFF > TIMEOUT_TICKS) ? MAX_ON_OFF : TIMEOUT_TICKS;
    localparam int TW         = $clog2(MAX_T + 1);
    localparam int IW         = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [TW-1:0] T_ONE    = TW'(1);
    localparam logic [TW-1:0] ON_LAST  = TW'(ON_TICKS - 1);
    localparam logic [TW-1:0] OFF_LAST = TW'(OFF_TICKS - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_TICKS - 1);
    localparam logic [LW-1:0] LEN_ONE  = LW'(1);
    localparam logic [LW-1:0] LEN_MAX  = LW'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ADD      = 3'd1,
        S_PLAY_ON  = 3'd2,
        S_PLAY_OFF = 3'd3,
        S_WAIT_IN  = 3'd4,
        S_SHOW_IN  = 3'd5,
        S_FAIL     = 3'd6,
        S_WIN      = 3'd7
    } state_t;

    state_t        state_q, state_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] idx_q, idx_d;
    logic [LW-1:0] score_q, score_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [1:0]    color_q, color_d;
    logic          led_q, led_d;
    logic          over_q, over_d;
    logic          win_q, win_d;
    logic          gap_q, gap_d;
    logic          seq_we;
    logic [LW-1:0] idx_inc;

    // Not reset: contents only become meaningful once written in ADD.
    logic [1:0] seq_q [MAX_LEN];

    always_ff @(posedge clk) begin
        if (seq_we) begin
            seq_q[len_q[IW-1:0]] <= rnd;
        end
    end

    assign idx_inc = idx_q + LEN_ONE;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        score_d = score_q;
        timer_d = timer_q + T_ONE;
        color_d = color_q;
        gap_d   = gap_q;
        seq_we  = 1'b0;

        case (state_q)
            S_IDLE, S_FAIL, S_WIN: begin
                timer_d = '0;
                if (start) begin
                    state_d = S_ADD;
                    len_d   = '0;
                    idx_d   = '0;
                    score_d = '0;
                    gap_d   = 1'b0;
                end
            end
            S_ADD: begin
                seq_we  = 1'b1;
                len_d   = len_q + LEN_ONE;
                idx_d   = '0;
                timer_d = '0;
                gap_d   = 1'b0;
                state_d = S_PLAY_ON;
            end
            S_PLAY_ON: begin
                if (timer_q == ON_LAST) begin
                    timer_d = '0;
                    state_d = S_PLAY_OFF;
                end
            end
            S_PLAY_OFF: begin
                if (timer_q == OFF_LAST) begin
                    timer_d = '0;
                    if (gap_q) begin
                        gap_d   = 1'b0;
                        state_d = S_ADD;
                    end else if (idx_inc < len_q) begin
                        idx_d   = idx_inc;
                        state_d = S_PLAY_ON;
                    end else begin
                        idx_d   = '0;
                        state_d = S_WAIT_IN;
                    end
                end
            end
            S_WAIT_IN: begin
                // A press on the timeout cycle takes priority over the timeout.
                if (press) begin
                    timer_d = '0;
                    if (press_color == seq_q[idx_q[IW-1:0]]) begin
                        color_d = press_color;
                        state_d = S_SHOW_IN;
                    end else begin
                        state_d = S_FAIL;
                    end
                end else if (timer_q == TO_LAST) begin
                    timer_d = '0;
                    state_d = S_FAIL;
                end
            end
            S_SHOW_IN: begin
                if (timer_q == ON_LAST) begin
                    timer_d = '0;
                    if (idx_inc < len_q) begin
                        idx_d   = idx_inc;
                        state_d = S_WAIT_IN;
                    end else begin
                        score_d = len_q;
                        if (len_q == LEN_MAX) begin
                            state_d = S_WIN;
                        end else begin
                            gap_d   = 1'b1;
                            state_d = S_PLAY_OFF;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // The entry written in ADD is not yet visible in seq_q, so forward rnd.
        if (state_d == S_PLAY_ON) begin
            color_d = (seq_we && (idx_d == len_q)) ? rnd : seq_q[idx_d[IW-1:0]];
        end
        led_d  = (state_d == S_PLAY_ON) || (state_d == S_SHOW_IN);
        over_d = (state_d == S_FAIL);
        win_d  = (state_d == S_WIN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            score_q <= '0;
            timer_q <= '0;
            color_q <= '0;
            led_q   <= 1'b0;
            over_q  <= 1'b0;
            win_q   <= 1'b0;
            gap_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            score_q <= score_d;
            timer_q <= timer_d;
            color_q <= color_d;
            led_q   <= led_d;
            over_q  <= over_d;
            win_q   <= win_d;
            gap_q   <= gap_d;
        end
    end

    assign state      = state_q;
    assign color      = color_q;
    assign led_enable = led_q;
    assign score      = score_q;
    assign game_over  = over_q;
    assign win        = win_q;

endmodule

// File: tb/tb_simon_sequencer.sv
// Directed bench for simon_sequencer with short timing parameters.
module tb_simon_sequencer;
    localparam int MAX_LEN = 3;
    localparam int ON_T    = 4;
    localparam int OFF_T   = 2;
    localparam int TO_T    = 20;
    localparam int LW      = $clog2(MAX_LEN + 1);

    logic          clk = 1'b0;
    logic          reset, start, press;
    logic [1:0]    press_color, rnd, color;
    logic          led_enable, game_over, win;
    logic [2:0]    state;
    logic [LW-1:0] score;

    int n_checks = 0;
    int n_pass   = 0;

    logic [1:0] model_seq [MAX_LEN];
    int         model_len = 0;

    always #5 clk = ~clk;

    simon_sequencer #(
        .MAX_LEN(MAX_LEN), .ON_TICKS(ON_T), .OFF_TICKS(OFF_T), .TIMEOUT_TICKS(TO_T)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .press(press),
        .press_color(press_color), .rnd(rnd), .color(color),
        .led_enable(led_enable), .state(state), .score(score),
        .game_over(game_over), .win(win)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic playback(input bit noisy);
        for (int k = 0; k < model_len; k++) begin
            for (int c = 0; c < ON_T; c++) begin
                n_checks++;
                if ({state, led_enable, color} !== {3'd2, 1'b1, model_seq[k]})
                    $display("FAIL play_on[%0d.%0d]: got st=%0d led=%0d col=%0d, want st=2 led=1 col=%0d",
                             k, c, state, led_enable, color, model_seq[k]);
                else n_pass++;
                press = noisy; start = noisy; press_color = ~model_seq[k];
                step;
            end
            for (int c = 0; c < OFF_T; c++) begin
                n_checks++;
                if ({state, led_enable} !== {3'd3, 1'b0})
                    $display("FAIL play_off[%0d.%0d]: got st=%0d led=%0d, want st=3 led=0", k, c, state, led_enable);
                else n_pass++;
                press = noisy; start = noisy; press_color = ~model_seq[k];
                step;
            end
        end
        press = 1'b0; start = 1'b0;
        n_checks++;
        if ({state, led_enable} !== {3'd4, 1'b0})
            $display("FAIL enter_wait: got st=%0d led=%0d, want st=4 led=0", state, led_enable);
        else n_pass++;
    endtask

    task automatic replay(input bit noisy);
        logic [2:0] exp_st;
        for (int k = 0; k < model_len; k++) begin
            press = 1'b1; press_color = model_seq[k];
            step;
            press = 1'b0;
            for (int c = 0; c < ON_T; c++) begin
                n_checks++;
                if ({state, led_enable, color} !== {3'd5, 1'b1, model_seq[k]})
                    $display("FAIL echo[%0d.%0d]: got st=%0d led=%0d col=%0d, want st=5 led=1 col=%0d",
                             k, c, state, led_enable, color, model_seq[k]);
                else n_pass++;
                press = noisy; start = noisy; press_color = ~model_seq[k];
                step;
            end
            press = 1'b0; start = 1'b0;
            if (k < model_len - 1) begin
                n_checks++;
                if (state !== 3'd4) $display("FAIL next_press: got st=%0d want 4", state);
                else n_pass++;
            end else begin
                exp_st = (model_len == MAX_LEN) ? 3'd7 : 3'd3;
                n_checks++;
                if ({state, score} !== {exp_st, LW'(model_len)})
                    $display("FAIL round_end: got st=%0d score=%0d, want st=%0d score=%0d",
                             state, score, exp_st, model_len);
                else n_pass++;
            end
        end
    endtask

    task automatic next_round(input logic [1:0] r);
        rnd = r;
        step;
        n_checks++;
        if ({state, led_enable} !== {3'd3, 1'b0})
            $display("FAIL gap: got st=%0d led=%0d, want st=3 led=0", state, led_enable);
        else n_pass++;
        step;
        n_checks++;
        if (state !== 3'd1) $display("FAIL gap_to_add: got st=%0d want 1", state);
        else n_pass++;
        step;
        model_seq[model_len] = r;
        model_len++;
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; press = 1'b0; press_color = 2'd0; rnd = 2'd0;
        step; step;
        n_checks++;
        if (state !== 3'd0) $display("FAIL reset_state: got %0d want 0", state); else n_pass++;
        n_checks++;
        if ({led_enable, color} !== 3'b000) $display("FAIL reset_led: got led=%0d col=%0d want 0/0", led_enable, color);
        else n_pass++;
        n_checks++;
        if ({score, game_over, win} !== '0)
            $display("FAIL reset_flags: got score=%0d go=%0d win=%0d want 0", score, game_over, win);
        else n_pass++;
        reset = 1'b0;
        step;
        press = 1'b1; press_color = 2'd1;
        step;
        press = 1'b0;
        n_checks++;
        if ({state, led_enable} !== {3'd0, 1'b0}) $display("FAIL idle_press: got st=%0d led=%0d want 0/0", state, led_enable);
        else n_pass++;
    endtask

    task automatic test_first_round;
        model_len = 0;
        rnd = 2'd2; start = 1'b1;
        step;
        start = 1'b0;
        n_checks++;
        if (state !== 3'd1) $display("FAIL start_add: got st=%0d want 1", state); else n_pass++;
        step;
        model_seq[0] = 2'd2; model_len = 1;
        playback(1'b0);
    endtask

    task automatic test_echo_and_round2;
        replay(1'b0);
        next_round(2'd1);
        playback(1'b0);
    endtask

    task automatic test_full_game;
        replay(1'b1);
        next_round(2'd3);
        playback(1'b1);
        replay(1'b0);
        n_checks++;
        if ({win, game_over, led_enable} !== 3'b100)
            $display("FAIL win_flags: got win=%0d go=%0d led=%0d want 1/0/0", win, game_over, led_enable);
        else n_pass++;
        press = 1'b1; press_color = 2'd0;
        step;
        press = 1'b0;
        n_checks++;
        if (state !== 3'd7) $display("FAIL win_hold: got st=%0d want 7", state); else n_pass++;
        start = 1'b1; rnd = 2'd2;
        step;
        start = 1'b0;
        n_checks++;
        if ({state, score, win} !== {3'd1, LW'(0), 1'b0})
            $display("FAIL win_restart: got st=%0d score=%0d win=%0d want 1/0/0", state, score, win);
        else n_pass++;
    endtask

    task automatic test_wrong_colour;
        model_len = 0;
        step;
        model_seq[0] = 2'd2; model_len = 1;
        playback(1'b0);
        replay(1'b0);
        next_round(2'd1);
        playback(1'b0);
        press = 1'b1; press_color = 2'd0;
        step;
        press = 1'b0;
        n_checks++;
        if ({state, game_over, score, led_enable} !== {3'd6, 1'b1, LW'(1), 1'b0})
            $display("FAIL mismatch: got st=%0d go=%0d score=%0d led=%0d want 6/1/1/0",
                     state, game_over, score, led_enable);
        else n_pass++;
        press = 1'b1; press_color = 2'd2;
        step;
        press = 1'b0;
        n_checks++;
        if (state !== 3'd6) $display("FAIL fail_hold: got st=%0d want 6", state); else n_pass++;
        start = 1'b1; press = 1'b1; rnd = 2'd3;
        step;
        start = 1'b0; press = 1'b0;
        n_checks++;
        if ({state, game_over, score} !== {3'd1, 1'b0, LW'(0)})
            $display("FAIL start_wins: got st=%0d go=%0d score=%0d want 1/0/0", state, game_over, score);
        else n_pass++;
    endtask

    task automatic test_timeout;
        model_len = 0;
        step;
        model_seq[0] = 2'd3; model_len = 1;
        playback(1'b0);
        for (int i = 0; i < TO_T; i++) begin
            n_checks++;
            if (state !== 3'd4) $display("FAIL wait_cycle[%0d]: got st=%0d want 4", i, state); else n_pass++;
            step;
        end
        n_checks++;
        if ({state, game_over} !== {3'd6, 1'b1})
            $display("FAIL timeout: got st=%0d go=%0d want 6/1", state, game_over);
        else n_pass++;
        start = 1'b1; rnd = 2'd3;
        step;
        start = 1'b0;
        step;
        playback(1'b0);
        for (int i = 0; i < TO_T - 1; i++) step;
        n_checks++;
        if (state !== 3'd4) $display("FAIL last_wait: got st=%0d want 4", state); else n_pass++;
        press = 1'b1; press_color = 2'd3;
        step;
        press = 1'b0;
        n_checks++;
        if ({state, game_over, color} !== {3'd5, 1'b0, 2'd3})
            $display("FAIL press_on_timeout: got st=%0d go=%0d col=%0d want 5/0/3", state, game_over, color);
        else n_pass++;
        for (int i = 0; i < ON_T; i++) step;
        n_checks++;
        if ({state, score} !== {3'd3, LW'(1)})
            $display("FAIL timeout_round: got st=%0d score=%0d want 3/1", state, score);
        else n_pass++;
    endtask

    task automatic test_reset_mid_play;
        next_round(2'd0);
        step;
        n_checks++;
        if ({state, led_enable, color} !== {3'd2, 1'b1, 2'd3})
            $display("FAIL pre_reset: got st=%0d led=%0d col=%0d want 2/1/3", state, led_enable, color);
        else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({state, led_enable, color, score, game_over, win} !== '0)
            $display("FAIL async_reset: got st=%0d led=%0d col=%0d score=%0d go=%0d win=%0d want all 0",
                     state, led_enable, color, score, game_over, win);
        else n_pass++;
        step;
        reset = 1'b0;
        step;
        n_checks++;
        if (state !== 3'd0) $display("FAIL post_reset: got st=%0d want 0", state); else n_pass++;
    endtask

    initial begin
        test_reset;
        test_first_round;
        test_echo_and_round2;
        test_full_game;
        test_wrong_colour;
        test_timeout;
        test_reset_mid_play;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
